fft_stage_ctrl: RTL and testbench
=================================

Name: fft_stage_ctrl

Overview:
- Sequencer for the parallel radix-2^2 FFT datapath: a chain of NUM_STAGES registered butterfly/twiddle stages, 1-cycle latency each, LANES samples per cycle.
- Enforces input frame sync and generates the per-stage `en` strobes.
- Carries each block's in-frame index down the pipe, for twiddle/rotator selection.
- Produces output framing (valid/sop/eop) and status.
- No data passes through this block; control only.

Parameters:
- N_POINTS, 512, FFT length in samples.
- LANES, 16, samples accepted per cycle (butterfly bundle width).
- NUM_STAGES, 9, number of 1-cycle pipeline stages sequenced.
- FRAME_CYC, N_POINTS/LANES (32), blocks per frame; derived, not overridable.
- IDX_W, $clog2(FRAME_CYC) (5), block-index width; derived.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din_valid  in  1  input block present this cycle
- din_sop  in  1  block is the first of a frame; qualified by din_valid
- clr_err  in  1  synchronous clear of the sticky error status
- stage_en  out  NUM_STAGES  stage_en[s] drives the `en` input of stage s
- stage_idx  out  NUM_STAGES x IDX_W  block index of the data at stage s input
- dout_valid  out  1  last stage output is valid
- dout_sop  out  1  output block index == 0
- dout_eop  out  1  output block index == FRAME_CYC-1
- frame_done  out  1  1-cycle pulse, coincident with dout_valid & dout_eop
- busy  out  1  frame in acceptance or any valid block still in the pipe
- sync_err  out  1  sticky: protocol violation seen at input

Behaviour:
- Reset: every output 0, FSM in IDLE, in_idx = 0, all pipe valid/index registers 0. Reset mid-frame discards the frame; no frame_done is produced for it.
- FSM IDLE:
  - din_valid & din_sop: accept the block, in_idx <= 1, go to RUN.
  - din_valid & ~din_sop: block dropped (stage_en[0] = 0); sync_err <= 1.
- FSM RUN:
  - din_valid & ~din_sop: accept, in_idx <= in_idx+1.
  - On accepting in_idx == FRAME_CYC-1: in_idx <= 0, go to IDLE.
  - din_valid & din_sop while in_idx != 0: sync_err <= 1. The block is accepted as index 0 of a new frame (in_idx <= 1, stay RUN). The truncated frame already in the pipe drains normally but never produces eop/frame_done.
  - din_valid low: gap; in_idx holds. No timeout.
- Acceptance: acc = din_valid & (RUN | din_sop). stage_en[0] = acc (combinational from inputs and FSM). stage_idx[0] = din_sop ? 0 : in_idx.
- Pipe: registered shift of {valid, idx}. stage_en[s] = vld[s-1] and stage_idx[s] = idx[s-1] for s >= 1. The chain always advances; there is no backpressure, and gaps propagate as bubbles.
- Output: dout_valid = vld[NUM_STAGES-1], exactly NUM_STAGES cycles after acceptance.
  - dout_sop / dout_eop decode from the output idx, gated by dout_valid.
  - frame_done = dout_valid & dout_eop.
- busy = (state == RUN) | (|vld).
- sync_err: set by a violation, cleared by clr_err. If both occur in the same cycle, set wins.
- Back-to-back frames with no idle cycle are legal (sop immediately after the eop block is accepted in IDLE).

Optional Feature:
- FFT_CTRL_STATS_EN defined:
  - Adds output err_cnt [15:0], counting violations and saturating at 0xFFFF; cleared by clr_err.
  - Adds output frame_cnt [15:0], incremented on frame_done and wrapping.
  - Both reset to 0.
- Not defined: neither port exists and no counter logic is generated.

Decomposition:
- Package fft_pkg holds:
  - N_POINTS, LANES, FRAME_CYC, IDX_W constants;
  - enum ctrl_state_t {IDLE, RUN};
  - struct pipe_tag_t {logic vld; logic [IDX_W-1:0] idx;}.
- One natural sub-module: fft_tag_pipe, a parameterised NUM_STAGES-deep shift register of pipe_tag_t with async reset. The FSM and status logic stay in the top.

Test Plan:
- 32 consecutive valid blocks, sop on the first:
  - stage_en[0] high for 32 cycles, stage_idx[0] = 0..31;
  - dout_valid high 9 cycles later for 32 cycles;
  - dout_sop on the first, dout_eop and frame_done on the 32nd;
  - busy falls the cycle after the last output.
- Same frame with din_valid low every other cycle: indices still 0..31 in order, bubbles visible on dout_valid, a single frame_done, sync_err stays 0.
- din_valid without sop in IDLE: stage_en[0] = 0, sync_err = 1; clr_err then returns it to 0; clr_err in the same cycle as a new violation keeps it at 1.
- sop at in_idx = 10:
  - sync_err = 1, stage_idx[0] = 0;
  - the first 10 blocks exit without eop/frame_done;
  - the new frame completes with one frame_done.
- Two frames back-to-back: 64 continuous dout_valid cycles, frame_done at output cycles 32 and 64.
- Assert rst_n mid-frame at in_idx = 15: all outputs 0 immediately; after release, a fresh sop frame completes normally. With FFT_CTRL_STATS_EN: frame_cnt = 1, err_cnt = 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2^2 FFT stage sequencer.
// Frame geometry lives here so the sequencer and its tag pipe agree on widths.
package fft_pkg;

    localparam int N_POINTS  = 512;
    localparam int LANES     = 16;
    localparam int FRAME_CYC = N_POINTS / LANES;
    localparam int IDX_W     = $clog2(FRAME_CYC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } pipe_tag_t;

endpackage

// File: rtl/fft_tag_pipe.sv
// NUM_STAGES-deep shift register of {valid, block index} tags that runs in
// lock-step with the datapath stages; it always advances, so gaps become bubbles.
module fft_tag_pipe
    import fft_pkg::*;
#(
    parameter int NUM_STAGES = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  pipe_tag_t                      in_tag,
    output pipe_tag_t [NUM_STAGES-1:0]     tags
);

    // NOTE: every tag register is reset, not only the valid bits, so the
    // index taps read 0 after reset instead of stale values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags <= '0;
        end else begin
            tags[0] <= in_tag;
            for (int s = 1; s < NUM_STAGES; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Frame-sync sequencer for the FFT pipeline: accepts blocks, emits per-stage
// enables and indices, and frames the output. Optional FFT_CTRL_STATS_EN adds counters.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int NUM_STAGES = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din_valid,
    input  logic                          din_sop,
    input  logic                          clr_err,
    output logic [NUM_STAGES-1:0]         stage_en,
    output logic [NUM_STAGES*IDX_W-1:0]   stage_idx,
    output logic                          dout_valid,
    output logic                          dout_sop,
    output logic                          dout_eop,
    output logic                          frame_done,
    output logic                          busy,
    output logic                          sync_err
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [15:0]                   err_cnt,
    output logic [15:0]                   frame_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CYC - 1);

    ctrl_state_t                 state;
    logic [IDX_W-1:0]            in_idx;
    logic                        acc;
    logic                        violation;
    logic [IDX_W-1:0]            idx_in;
    pipe_tag_t                   in_tag;
    pipe_tag_t [NUM_STAGES-1:0]  tags;
    logic                        any_vld;
    logic [IDX_W-1:0]            out_idx;

    // A sop always restarts a frame; a non-sop block is only taken inside one.
    assign acc       = din_valid & ((state == RUN) | din_sop);
    assign violation = din_valid & ((state == IDLE) ? ~din_sop
                                                    : (din_sop & (in_idx != '0)));
    assign idx_in    = din_sop ? '0 : in_idx;
    assign in_tag    = '{vld: acc, idx: idx_in};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            in_idx <= '0;
        end else if (acc) begin
            if (din_sop) begin
                state  <= RUN;
                in_idx <= IDX_W'(1);
            end else if (in_idx == LAST_IDX) begin
                state  <= IDLE;
                in_idx <= '0;
            end else begin
                in_idx <= in_idx + 1'b1;
            end
        end
    end

    fft_tag_pipe #(
        .NUM_STAGES (NUM_STAGES)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_tag (in_tag),
        .tags   (tags)
    );

    assign stage_en[0]            = acc;
    assign stage_idx[IDX_W-1:0]   = idx_in;

    for (genvar s = 1; s < NUM_STAGES; s++) begin : g_tap
        assign stage_en[s]                 = tags[s-1].vld;
        assign stage_idx[s*IDX_W +: IDX_W] = tags[s-1].idx;
    end

    // NOTE: the accumulator gets a default before the loop so no latch is inferred.
    always_comb begin
        any_vld = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            any_vld = any_vld | tags[s].vld;
        end
    end

    assign out_idx    = tags[NUM_STAGES-1].idx;
    assign dout_valid = tags[NUM_STAGES-1].vld;
    assign dout_sop   = dout_valid & (out_idx == '0);
    assign dout_eop   = dout_valid & (out_idx == LAST_IDX);
    assign frame_done = dout_eop;
    assign busy       = (state == RUN) | any_vld;

    // A violation in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
        end else if (violation) begin
            sync_err <= 1'b1;
        end else if (clr_err) begin
            sync_err <= 1'b0;
        end
    end

`ifdef FFT_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            if (clr_err) begin
                err_cnt <= {15'd0, violation};
            end else if (violation && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: directed frames plus random traffic,
// compared every cycle against a time-history reference model of the frame rules.
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    localparam int NUM_STAGES = 9;
    localparam int HIST       = 4096;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_CYC - 1);

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        din_valid = 1'b0;
    logic                        din_sop = 1'b0;
    logic                        clr_err = 1'b0;
    logic [NUM_STAGES-1:0]       stage_en;
    logic [NUM_STAGES*IDX_W-1:0] stage_idx;
    logic                        dout_valid, dout_sop, dout_eop, frame_done, busy, sync_err;
`ifdef FFT_CTRL_STATS_EN
    logic [15:0]                 err_cnt, frame_cnt;
`endif

    fft_stage_ctrl #(.NUM_STAGES(NUM_STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .clr_err    (clr_err),
        .stage_en   (stage_en),
        .stage_idx  (stage_idx),
        .dout_valid (dout_valid),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .frame_done (frame_done),
        .busy       (busy),
        .sync_err   (sync_err)
`ifdef FFT_CTRL_STATS_EN
        ,
        .err_cnt    (err_cnt),
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame position, sticky error, acceptance history by cycle.
    int               t = 0;
    int               hist_base = 0;
    bit               in_frame = 0;
    int               nidx = 0;
    bit               serr = 0;
    int               m_err_cnt = 0;
    int               m_frame_cnt = 0;
    bit               acc_hist [HIST];
    logic [IDX_W-1:0] idx_hist [HIST];
    int               fd_seen = 0;
    int               dv_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic bit hacc(input int k);
        return (k >= hist_base) ? acc_hist[k] : 1'b0;
    endfunction

    function automatic logic [IDX_W-1:0] hidx(input int k);
        return (k >= hist_base) ? idx_hist[k] : '0;
    endfunction

    task automatic step(input logic v, input logic s, input logic c);
        bit               acc, viol, ov, exp_busy;
        logic [IDX_W-1:0] idx0, oidx;
        @(negedge clk);
        din_valid = v;
        din_sop   = s;
        clr_err   = c;
        #1;
        acc  = v && (in_frame || s);
        viol = v && (in_frame ? (s && nidx != 0) : !s);
        idx0 = s ? '0 : IDX_W'(nidx);
        acc_hist[t] = acc;
        idx_hist[t] = idx0;

        chk("stage_en0", stage_en[0], acc);
        chk("stage_idx0", stage_idx[IDX_W-1:0], idx0);
        for (int k = 1; k < NUM_STAGES; k++) begin
            chk($sformatf("stage_en%0d", k), stage_en[k], hacc(t - k));
            if (hacc(t - k))
                chk($sformatf("stage_idx%0d", k), stage_idx[k*IDX_W +: IDX_W], hidx(t - k));
        end
        ov   = hacc(t - NUM_STAGES);
        oidx = hidx(t - NUM_STAGES);
        chk("dout_valid", dout_valid, ov);
        chk("dout_sop", dout_sop, ov && oidx == '0);
        chk("dout_eop", dout_eop, ov && oidx == LAST_IDX);
        chk("frame_done", frame_done, ov && oidx == LAST_IDX);
        exp_busy = in_frame;
        for (int k = 1; k <= NUM_STAGES; k++) exp_busy = exp_busy | hacc(t - k);
        chk("busy", busy, exp_busy);
        chk("sync_err", sync_err, serr);
`ifdef FFT_CTRL_STATS_EN
        chk("err_cnt", err_cnt, m_err_cnt);
        chk("frame_cnt", frame_cnt, m_frame_cnt);
`endif
        if (frame_done === 1'b1) fd_seen++;
        if (dout_valid === 1'b1) dv_seen++;

        if (acc) begin
            if (s) begin
                in_frame = 1;
                nidx     = 1;
            end else begin
                nidx++;
            end
            if (nidx == FRAME_CYC) begin
                in_frame = 0;
                nidx     = 0;
            end
        end
        serr = viol ? 1'b1 : (c ? 1'b0 : serr);
        if (c) m_err_cnt = viol ? 1 : 0;
        else if (viol && m_err_cnt != 16'hFFFF) m_err_cnt++;
        if (ov && oidx == LAST_IDX) m_frame_cnt = (m_frame_cnt + 1) & 16'hFFFF;
        t++;
    endtask

    task automatic drain();
        repeat (NUM_STAGES + 3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        clr_err   = 1'b0;
        #1;
        chk("rst_stage_en", stage_en, '0);
        chk("rst_stage_idx", stage_idx, '0);
        chk("rst_dout", {dout_valid, dout_sop, dout_eop, frame_done}, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sync_err", sync_err, 1'b0);
`ifdef FFT_CTRL_STATS_EN
        chk("rst_err_cnt", err_cnt, 16'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        in_frame    = 0;
        nidx        = 0;
        serr        = 0;
        m_err_cnt   = 0;
        m_frame_cnt = 0;
        hist_base   = t;
    endtask

    initial begin
        do_reset();

        // Continuous frame.
        fd_seen = 0; dv_seen = 0;
        for (int i = 0; i < FRAME_CYC; i++) step(1'b1, i == 0, 1'b0);
        drain();
        chk("frame1_done_count", fd_seen, 1);
        chk("frame1_dout_count", dv_seen, FRAME_CYC);

        // Same frame with a gap every other cycle.
        fd_seen = 0; dv_seen = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            step(1'b1, i == 0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        drain();
        chk("gap_done_count", fd_seen, 1);
        chk("gap_sync_err", sync_err, 1'b0);

        // Protocol violation in IDLE, clear, and clear colliding with a violation.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("viol_sticky", sync_err, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("viol_cleared", sync_err, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("viol_set_wins", sync_err, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Early sop at in_idx = 10 truncates the first frame.
        fd_seen = 0;
        for (int i = 0; i < 10; i++) step(1'b1, i == 0, 1'b0);
        for (int i = 0; i < FRAME_CYC; i++) step(1'b1, i == 0, 1'b0);
        drain();
        chk("early_sop_err", sync_err, 1'b1);
        chk("early_sop_done_count", fd_seen, 1);
        step(1'b0, 1'b0, 1'b1);

        // Two frames back-to-back.
        fd_seen = 0; dv_seen = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) step(1'b1, (i % FRAME_CYC) == 0, 1'b0);
        drain();
        chk("b2b_done_count", fd_seen, 2);
        chk("b2b_dout_count", dv_seen, 2 * FRAME_CYC);

        // Reset in the middle of a frame, then a fresh frame.
        for (int i = 0; i < 15; i++) step(1'b1, i == 0, 1'b0);
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < FRAME_CYC; i++) step(1'b1, i == 0, 1'b0);
        drain();
        chk("post_rst_done_count", fd_seen, 1);
`ifdef FFT_CTRL_STATS_EN
        chk("post_rst_frame_cnt", frame_cnt, 16'd1);
        chk("post_rst_err_cnt", err_cnt, 16'd0);
`endif

        // Random traffic: gaps, occasional stray sops, occasional clears.
        for (int i = 0; i < 600; i++) begin
            logic v, s, c;
            v = ($urandom % 4) != 0;
            s = (!in_frame && ($urandom % 2) == 1) || ($urandom % 64) == 0;
            c = ($urandom % 50) == 0;
            step(v, s, c);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
